// File: rtl/uart_encoder.sv
// uart_encoder: frames game events into SYNC/TYPE/P0/P1/P2[/CHK] bytes for the uart TX FIFO; define UART_ENC_CHECKSUM_EN to append the CHK byte
module uart_encoder #(
  parameter int         KEEPER_PERIOD = 1_083_333,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_en,
  input  logic        connect_req,
  input  logic        shot_req,
  input  logic [11:0] shot_xpos,
  input  logic [11:0] shot_ypos,
  input  logic        score_req,
  input  logic [2:0]  score_player,
  input  logic [2:0]  score_enemy,
  input  logic [11:0] keeper_xpos,
  input  logic [11:0] keeper_ypos,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy,
  output logic [15:0] frames_sent
);
`ifdef UART_ENC_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd4;
`endif
  localparam int TW = $clog2(KEEPER_PERIOD);
  localparam logic [TW-1:0] TICK_MAX = TW'(KEEPER_PERIOD - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [3:0] flag, grant, req;
  logic [TW-1:0] tick;
  logic [11:0] shot_x, shot_y, keep_x, keep_y;
  logic [2:0] sc_p, sc_e;
  logic [5:0][7:0] frame;
  logic [2:0] idx;
  logic [7:0] typ, p0, p1, p2;
  logic keep_tick, load, last_wr;
  assign keep_tick = link_en && tick == TICK_MAX;
  assign req = {keep_tick, score_req, shot_req, connect_req} & {4{link_en}};
  // winning pending type (bit 0 highest priority) and its payload bytes
  always_comb begin
    grant = flag[0] ? 4'b0001 : flag[1] ? 4'b0010 : flag[2] ? 4'b0100 : {flag[3], 3'b000};
    typ = flag[0] ? 8'h01 : flag[1] ? 8'h03 : flag[2] ? 8'h04 : 8'h02;
    p0 = flag[0] ? 8'h00 : flag[1] ? shot_x[11:4] : flag[2] ? {2'b00, sc_p, sc_e} : keep_x[11:4];
    p1 = flag[0] ? 8'h00 : flag[1] ? {shot_x[3:0], shot_y[11:8]} : flag[2] ? 8'h00 : {keep_x[3:0], keep_y[11:8]};
    p2 = flag[0] ? 8'h00 : flag[1] ? shot_y[7:0] : flag[2] ? 8'h00 : keep_y[7:0];
  end
  // keeper period counter, parked at zero while the link is down
  always_ff @(posedge clk or posedge rst)
    if (rst) tick <= '0;
    else tick <= (!link_en || keep_tick) ? '0 : tick + 1'b1;
  // pending flags: requests set, the loaded type clears, link drop clears all; a new request beats the clear
  always_ff @(posedge clk or posedge rst)
    if (rst) flag <= '0;
    else flag <= link_en ? (flag & ~(load ? grant : 4'b0)) | req : 4'b0;
  // payload snapshots, latest request wins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {shot_x, shot_y, keep_x, keep_y} <= '0;
      {sc_p, sc_e} <= '0;
    end else begin
      if (req[1]) {shot_x, shot_y} <= {shot_xpos, shot_ypos};
      if (req[2]) {sc_p, sc_e} <= {score_player, score_enemy};
      if (keep_tick) {keep_x, keep_y} <= {keeper_xpos, keeper_ypos};
    end
  // FSM next state and FIFO write interface
  always_comb begin
    load = state == IDLE && link_en && |flag;
    wr_uart = state == SEND && !tx_full;
    last_wr = wr_uart && idx == LAST;
    w_data = state == SEND ? frame[idx] : 8'h00;
    busy = state == SEND;
    state_nx = load ? SEND : last_wr ? IDLE : state;
  end
  // state, frame register, byte index and completed-frame counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      idx <= '0;
      frames_sent <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        frame <= {typ ^ p0 ^ p1 ^ p2, p2, p1, p0, typ, SYNC_BYTE};
        idx <= '0;
      end else if (wr_uart) idx <= idx + 3'd1;
      if (last_wr) frames_sent <= frames_sent + 16'd1;
    end
endmodule

// File: tb/tb_uart_encoder.sv
// tb_uart_encoder: scoreboard bench for uart_encoder with directed and randomized frame traffic
module tb_uart_encoder;
`ifdef UART_ENC_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  logic clk, rst, link_en, connect_req, shot_req, score_req, tx_full;
  logic [11:0] shot_xpos, shot_ypos, keeper_xpos, keeper_ypos;
  logic [2:0] score_player, score_enemy;
  logic [7:0] w_data;
  logic wr_uart, busy;
  logic [15:0] frames_sent;
  int checks = 0, errors = 0, nwr = 0, nb = 0, tx_mode = 0, tx_cnt = 0;
  int base, x1, y1, x2, y2, sel;
  logic [15:0] fs0;
  logic [47:0] qc[$], qs[$], qr[$];
  logic [47:0] kexp, fr, got, e;
  logic [7:0] types[$];
  bit have;

  uart_encoder #(.KEEPER_PERIOD(16)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .connect_req(connect_req),
    .shot_req(shot_req), .shot_xpos(shot_xpos), .shot_ypos(shot_ypos),
    .score_req(score_req), .score_player(score_player), .score_enemy(score_enemy),
    .keeper_xpos(keeper_xpos), .keeper_ypos(keeper_ypos), .tx_full(tx_full),
    .w_data(w_data), .wr_uart(wr_uart), .busy(busy), .frames_sent(frames_sent)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int t, input int a, input int b, input int c);
    logic [47:0] f;
    f = {8'hA5, 8'(t), 8'(a), 8'(b), 8'(c), 8'(t ^ a ^ b ^ c)};
    return FLEN == 6 ? f : {f[47:8], 8'h00};
  endfunction
  function automatic logic [47:0] pos(input int t, input int x, input int y);
    return mk(t, x / 16, (x % 16) * 16 + y / 256, y % 256);
  endfunction
  function automatic logic [47:0] scr(input int p, input int en);
    return mk(4, p * 8 + en, 0, 0);
  endfunction
  function automatic logic [47:0] cst(input logic [47:0] c);
    return FLEN == 6 ? c : {c[47:8], 8'h00};
  endfunction

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_sent(input logic [15:0] target, input int budget);
    for (int i = 0; i < budget && frames_sent != target; i++) tk(1);
    check(frames_sent == target, "wait_sent", frames_sent, target);
  endtask
  task automatic wait_nwr(input int target, input int budget);
    for (int i = 0; i < budget && nwr != target; i++) tk(1);
    check(nwr == target, "wait_writes", nwr, target);
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && (qc.size() + qs.size() + qr.size() != 0 || busy); i++) tk(1);
    check(qc.size() + qs.size() + qr.size() == 0 && !busy, "drain", qc.size() + qs.size() + qr.size(), 0);
  endtask

  // FIFO backpressure: 0 = never full, 1 = random, 2 = toggles every 3 cycles
  always @(posedge clk) begin
    #1;
    tx_cnt++;
    tx_full = tx_mode == 2 ? ((tx_cnt / 3) % 2 == 1) : tx_mode == 1 ? ($urandom_range(3) == 0) : 1'b0;
  end

  // monitor: assemble frames from FIFO writes and match against the expected queue for their type
  always @(negedge clk) begin
    if (rst) begin
      nb = 0;
      fr = '0;
    end else begin
      check(wr_uart == (busy && !tx_full), "wr_rule", wr_uart, busy && !tx_full);
      if (!busy) check(w_data == 8'h00, "idle_data", w_data, 0);
      if (wr_uart) begin
        fr = {fr[39:0], w_data};
        nb++;
        nwr++;
        if (nb == FLEN) begin
          got = FLEN == 6 ? fr : {fr[39:0], 8'h00};
          types.push_back(got[39:32]);
          have = 0;
          e = '0;
          case (got[39:32])
            8'h01: if (qc.size() > 0) begin have = 1; e = qc.pop_front(); end
            8'h03: if (qs.size() > 0) begin have = 1; e = qs.pop_front(); end
            8'h04: if (qr.size() > 0) begin have = 1; e = qr.pop_front(); end
            8'h02: begin have = 1; e = kexp; end
            default: have = 0;
          endcase
          check(have && got == e, "frame", got, e);
          nb = 0;
          fr = '0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; link_en = 0; connect_req = 0; shot_req = 0; score_req = 0;
    shot_xpos = 0; shot_ypos = 0; score_player = 0; score_enemy = 0;
    keeper_xpos = 0; keeper_ypos = 0; tx_full = 0; kexp = '0;
    tk(3);
    check(wr_uart == 0, "rst_wr", wr_uart, 0);
    check(w_data == 0, "rst_data", w_data, 0);
    check(busy == 0, "rst_busy", busy, 0);
    check(frames_sent == 0, "rst_sent", frames_sent, 0);
    rst = 0;
    tk(2);
    // periodic keeper frame and its latency
    types.delete();
    keeper_xpos = 12'h123; keeper_ypos = 12'h456;
    kexp = cst(48'hA5_02_12_34_56_72);
    link_en = 1;
    tk(16 + FLEN);
    check(frames_sent == 0 && busy, "keeper_latency", frames_sent, 0);
    tk(1);
    check(frames_sent == 1 && !busy, "keeper_sent", frames_sent, 1);
    link_en = 0;
    check(types.size() == 1 && types[0] == 8'h02, "keeper_type", types.size(), 1);
    tk(2);
    // simultaneous shot and score: shot wins
    types.delete();
    qs.push_back(cst(48'hA5_03_3F_F2_00_CE));
    qr.push_back(cst(48'hA5_04_1A_00_00_1E));
    shot_xpos = 12'h3FF; shot_ypos = 12'h200; score_player = 3; score_enemy = 2;
    shot_req = 1; score_req = 1; link_en = 1;
    tk(1);
    shot_req = 0; score_req = 0;
    wait_sent(16'd3, 40);
    link_en = 0;
    check(types.size() == 2 && types[0] == 8'h03 && types[1] == 8'h04, "priority_order", types.size(), 2);
    tk(2);
    // connect frame under toggling backpressure
    base = nwr;
    qc.push_back(cst(48'hA5_01_00_00_00_01));
    tx_mode = 2; link_en = 1; connect_req = 1;
    tk(1);
    connect_req = 0;
    tk(1);
    link_en = 0;
    wait_sent(16'd4, 80);
    tx_mode = 0;
    tk(2);
    check(nwr - base == FLEN, "connect_writes", nwr - base, FLEN);
    // asynchronous reset mid SCORE frame
    base = nwr;
    score_player = 3; score_enemy = 2; link_en = 1; score_req = 1;
    tk(1);
    score_req = 0;
    wait_nwr(base + 3, 20);
    #1 rst = 1;
    #1;
    check(wr_uart == 0, "arst_wr", wr_uart, 0);
    check(w_data == 0, "arst_data", w_data, 0);
    check(busy == 0, "arst_busy", busy, 0);
    check(frames_sent == 0, "arst_sent", frames_sent, 0);
    tk(2);
    rst = 0;
    base = nwr;
    tk(10);
    check(nwr == base, "post_reset_quiet", nwr - base, 0);
    check(frames_sent == 0, "post_reset_sent", frames_sent, 0);
    link_en = 0;
    tk(2);
    // requests ignored while link is down
    base = nwr; fs0 = frames_sent;
    repeat (5) begin
      shot_req = 1; connect_req = 1;
      tk(1);
      shot_req = 0; connect_req = 0;
      tk(3);
    end
    tk(100);
    check(nwr == base, "link_off_writes", nwr - base, 0);
    check(frames_sent == fs0, "link_off_sent", frames_sent, fs0);
    // link drop mid frame: in-flight connect completes, pending shot is discarded
    base = nwr; fs0 = frames_sent;
    qc.push_back(cst(48'hA5_01_00_00_00_01));
    shot_xpos = 12'h111; shot_ypos = 12'h222; link_en = 1; connect_req = 1; shot_req = 1;
    tk(1);
    connect_req = 0; shot_req = 0;
    wait_nwr(base + 2, 20);
    link_en = 0;
    tk(30);
    check(frames_sent == fs0 + 16'd1, "drop_sent", frames_sent, fs0 + 16'd1);
    check(nwr - base == FLEN, "drop_writes", nwr - base, FLEN);
    // latest payload wins while pending; same-type request during SEND is sent again
    keeper_xpos = 12'($urandom); keeper_ypos = 12'($urandom);
    kexp = pos(2, int'(keeper_xpos), int'(keeper_ypos));
    fs0 = frames_sent;
    x1 = $urandom_range(4095); y1 = $urandom_range(4095); x2 = $urandom_range(4095); y2 = $urandom_range(4095);
    link_en = 1; connect_req = 1; shot_req = 1; shot_xpos = 12'(x1); shot_ypos = 12'(y1);
    tk(1);
    connect_req = 0; shot_xpos = 12'(x2); shot_ypos = 12'(y2);
    tk(1);
    shot_req = 0;
    qc.push_back(cst(48'hA5_01_00_00_00_01));
    qs.push_back(pos(3, x2, y2));
    wait_sent(fs0 + 16'd1, 30);
    tk(3);
    x1 = $urandom_range(4095); y1 = $urandom_range(4095);
    shot_req = 1; shot_xpos = 12'(x1); shot_ypos = 12'(y1);
    tk(1);
    shot_req = 0;
    qs.push_back(pos(3, x1, y1));
    drain(100);
    link_en = 0;
    tk(2);
    // randomized batches with random backpressure
    repeat (40) begin
      keeper_xpos = 12'($urandom); keeper_ypos = 12'($urandom);
      kexp = pos(2, int'(keeper_xpos), int'(keeper_ypos));
      tx_mode = $urandom_range(1);
      sel = $urandom_range(7);
      x1 = $urandom_range(4095); y1 = $urandom_range(4095); x2 = $urandom_range(7); y2 = $urandom_range(7);
      shot_xpos = 12'(x1); shot_ypos = 12'(y1); score_player = 3'(x2); score_enemy = 3'(y2);
      connect_req = sel[0]; shot_req = sel[1]; score_req = sel[2];
      if (sel[0]) qc.push_back(mk(1, 0, 0, 0));
      if (sel[1]) qs.push_back(pos(3, x1, y1));
      if (sel[2]) qr.push_back(scr(x2, y2));
      link_en = 1;
      tk(1);
      connect_req = 0; shot_req = 0; score_req = 0;
      drain(300);
      link_en = 0;
      tx_mode = 0;
      tk(2);
    end
    tk(5);
    check(nb == 0, "partial_frame", nb, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_encoder.md
Name: uart_encoder

Overview:
- Transmit-side protocol framer for multiplayer mode; mirror of uart_decoder.
- Takes game events (connect request, keeper position, shot position, score) and serialises each into a fixed-length byte frame.
- Frames are pushed into the uart TX FIFO through its w_data/wr_uart/tx_full interface.
- Sits between gloves_control/ball_control/score_control/game_state_sel and uart.

Parameters:
- KEEPER_PERIOD, 1_083_333, clk cycles between periodic keeper-position frames (60 Hz at 65 MHz); must be ≥ 8.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- link_en  in  1  multiplayer link active; low = no new frames
- connect_req  in  1  one-cycle pulse: send CONNECT frame
- shot_req  in  1  one-cycle pulse: send SHOT frame
- shot_xpos  in  12  shot x, sampled on shot_req
- shot_ypos  in  12  shot y, sampled on shot_req
- score_req  in  1  one-cycle pulse: send SCORE frame
- score_player  in  3  player score, sampled on score_req
- score_enemy  in  3  enemy score, sampled on score_req
- keeper_xpos  in  12  keeper x, sampled at each period tick
- keeper_ypos  in  12  keeper y, sampled at each period tick
- tx_full  in  1  uart TX FIFO full
- w_data  out  8  byte to FIFO
- wr_uart  out  1  FIFO write strobe
- busy  out  1  frame in flight
- frames_sent  out  16  completed-frame counter, wraps at 0xFFFF→0

Behaviour:
- Frame layout: SYNC, TYPE, P0, P1, P2, CHK.
  - CHK = TYPE^P0^P1^P2.
  - Types: CONNECT=0x01, KEEPER=0x02, SHOT=0x03, SCORE=0x04.
- Position packing (KEEPER and SHOT): P0=x[11:4], P1={x[3:0],y[11:8]}, P2=y[7:0].
- SCORE packing: P0={2'b00,score_player,score_enemy}, P1=P2=0.
- CONNECT packing: P0=P1=P2=0.
- Pending flags and payload registers, one per type:
  - A request pulse with link_en=1 sets the flag and snapshots the payload.
  - A repeat request while the flag is still set overwrites the payload (latest wins); it is not queued twice.
- Keeper tick counter:
  - Counts 0..KEEPER_PERIOD-1 while link_en=1 and wraps.
  - On wrap it sets the KEEPER flag and snapshots keeper_xpos/ypos.
  - Held at 0 while link_en=0.
- Arbitration priority when multiple flags are set: CONNECT > SHOT > SCORE > KEEPER.
- FSM states: IDLE, SEND.
  - IDLE: if any flag is set, load the 6-byte frame register from the winning type, clear only that flag, clear byte index, go to SEND.
  - SEND: wr_uart = !tx_full (combinational); w_data = frame[idx].
    - On each clock with wr_uart=1, idx increments.
    - Write of idx=5 (last byte): frames_sent++, go to IDLE.
  - tx_full=1 stalls SEND indefinitely with no byte lost or duplicated.
- Latency: a request sampled at edge k sets its flag; the FSM loads at edge k+1; the first wr_uart is possible in the cycle after edge k+1.
  - Back-to-back bytes are written every cycle while tx_full=0.
  - Minimum frame gap is one IDLE cycle.
- A request arriving during SEND for the same type as the in-flight frame sets the flag again and is sent afterward.
- busy = (state==SEND).
- link_en falling:
  - All pending flags are cleared and further requests are ignored.
  - An in-flight frame still completes.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, flags=0, payloads=0, tick=0, idx=0, frames_sent=0.
  - wr_uart=0, w_data=0, busy=0.
  - A truncated frame on the wire is tolerated; the receiver resyncs on SYNC_BYTE.
- Outside SEND: wr_uart=0 and w_data=0.

Optional Feature:
- Macro: UART_ENC_CHECKSUM_EN.
- Defined: 6-byte frames with CHK as above; last idx=5.
- Undefined: 5-byte frames (no CHK byte); last idx=4; all other behaviour unchanged.

Test Plan:
- KEEPER_PERIOD=16, link_en=1, keeper=(0x123,0x456), tx_full=0 → after 16 cycles: bytes A5 02 12 34 56 72 on 6 consecutive wr_uart cycles; frames_sent=1.
- shot_req with (0x3FF,0x200) and score_req(3,2) in the same cycle → SHOT frame A5 03 3F F2 00 CE first, then SCORE frame A5 04 1A 00 00 1E; frames_sent=2.
- connect_req while tx_full toggles 1/0 every 3 cycles → exactly A5 01 00 00 00 01 written; no writes while tx_full=1.
- Reset asserted after 3rd byte of a SCORE frame → outputs zero immediately; after release with no requests, no further writes; frames_sent=0.
- link_en=0 with shot_req pulses and 100 cycles elapsed → no wr_uart.
- link_en dropped mid-frame → current frame completes and nothing follows.
- UART_ENC_CHECKSUM_EN undefined, connect_req → A5 01 00 00 00 (5 writes only).
